// File: rtl/useq_fifo_arb.sv
// useq mailbox FIFO port controller: round-robin write arbiter and 2-entry read drain buffer.
// Define USEQ_ARB_FIXED_PRIO_EN for fixed priority arbitration (lowest index wins).
module useq_fifo_arb #(
    parameter int NREQ       = 2,
    parameter int WIDTH      = 8,
    parameter int MIN_WR_GAP = 0,
    localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    input  logic                  rsp_ready,
    output logic                  write_fifo,
    output logic [WIDTH-1:0]      fifo_in,
    output logic                  read_fifo,
    input  logic [WIDTH-1:0]      fifo_out,
    input  logic                  fifo_empty,
    output logic [IW-1:0]         wr_owner
);

    typedef enum logic {WR_IDLE, WR_GAP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_WAIT} rd_state_e;

    wr_state_e        wr_state_q, wr_state_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             write_fifo_q, write_fifo_d;
    logic [WIDTH-1:0] fifo_in_q, fifo_in_d;
    logic [IW-1:0]    wr_owner_q, wr_owner_d;
`ifndef USEQ_ARB_FIXED_PRIO_EN
    logic [IW-1:0]    rr_q, rr_d;
`endif

    rd_state_e        rd_state_q, rd_state_d;
    logic             read_fifo_q, read_fifo_d;
    logic [WIDTH-1:0] buf_q [2];
    logic [WIDTH-1:0] buf_d [2];
    logic             head_q, head_d;
    logic [1:0]       count_q, count_d;

    logic             grant_found;
    logic [IW-1:0]    grant_idx;
    logic             accept;
    logic             push;
    logic             pop;
    logic             tail;
    logic             issue;

    // First valid requester at or after the rotating pointer
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef USEQ_ARB_FIXED_PRIO_EN
            if (!grant_found && req_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(k);
            end
`else
            if (!grant_found && req_valid[(int'(rr_q) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = IW'((int'(rr_q) + k) % NREQ);
            end
`endif
        end
    end

    assign accept    = !rst && (wr_state_q == WR_IDLE) && grant_found;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        wr_state_d   = wr_state_q;
        gap_cnt_d    = gap_cnt_q;
        write_fifo_d = accept;
        fifo_in_d    = fifo_in_q;
        wr_owner_d   = wr_owner_q;
`ifndef USEQ_ARB_FIXED_PRIO_EN
        rr_d         = rr_q;
`endif
        unique case (wr_state_q)
            WR_IDLE: begin
                if (accept) begin
                    fifo_in_d  = req_data[int'(grant_idx)*WIDTH +: WIDTH];
                    wr_owner_d = grant_idx;
`ifndef USEQ_ARB_FIXED_PRIO_EN
                    rr_d       = IW'((int'(grant_idx) + 1) % NREQ);
`endif
                    if (MIN_WR_GAP > 0) begin
                        wr_state_d = WR_GAP;
                        gap_cnt_d  = 4'(MIN_WR_GAP - 1);
                    end
                end
            end
            WR_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    wr_state_d = WR_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // A read is in flight from its strobe cycle until fifo_out is captured
    assign push  = (rd_state_q == RD_WAIT);
    assign pop   = (count_q != 2'd0) && rsp_ready;
    assign tail  = head_q ^ count_q[0];
    assign issue = !rst && !read_fifo_q && !fifo_empty &&
                   ((3'(count_q) + 3'(push)) < 3'd2);

    always_comb begin
        read_fifo_d = issue;
        rd_state_d  = read_fifo_q ? RD_WAIT : RD_IDLE;
        buf_d       = buf_q;
        head_d      = head_q;
        count_d     = count_q;
        if (push) begin
            buf_d[tail] = fifo_out;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q   <= WR_IDLE;
            gap_cnt_q    <= '0;
            write_fifo_q <= 1'b0;
            fifo_in_q    <= '0;
            wr_owner_q   <= '0;
`ifndef USEQ_ARB_FIXED_PRIO_EN
            rr_q         <= '0;
`endif
            rd_state_q   <= RD_IDLE;
            read_fifo_q  <= 1'b0;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            head_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            wr_state_q   <= wr_state_d;
            gap_cnt_q    <= gap_cnt_d;
            write_fifo_q <= write_fifo_d;
            fifo_in_q    <= fifo_in_d;
            wr_owner_q   <= wr_owner_d;
`ifndef USEQ_ARB_FIXED_PRIO_EN
            rr_q         <= rr_d;
`endif
            rd_state_q   <= rd_state_d;
            read_fifo_q  <= read_fifo_d;
            buf_q        <= buf_d;
            head_q       <= head_d;
            count_q      <= count_d;
        end
    end

    assign write_fifo = write_fifo_q;
    assign fifo_in    = fifo_in_q;
    assign wr_owner   = wr_owner_q;
    assign read_fifo  = read_fifo_q;
    assign rsp_valid  = (count_q != 2'd0);
    assign rsp_data   = buf_q[head_q];

endmodule
